// File: rtl/exe_pipe_regs_pkg.sv
// Shared control-bundle layout, forwarding/write-back codes and stage record types.
// Pure definitions; no latency or backpressure of its own.
package exe_pipe_regs_pkg;

    localparam int CTRL_W      = 13;
    localparam int C_REGWRITE  = 12;
    localparam int C_DTR_HI    = 11;
    localparam int C_DTR_LO    = 10;
    localparam int C_MEMWRITE  = 9;
    localparam int C_ALUSRCB   = 8;
    localparam int C_ALUCTL_HI = 7;
    localparam int C_ALUCTL_LO = 4;
    localparam int C_REGDST_HI = 3;
    localparam int C_REGDST_LO = 2;
    localparam int C_SORU      = 1;
    localparam int C_ALUSRCA   = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 13'b0;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EXE    = 2'b01,
        FWD_MEMRD  = 2'b10,
        FWD_MEMALU = 2'b11
    } fwd_e;

    typedef enum logic [1:0] {
        DTR_ALU  = 2'b00,
        DTR_LOAD = 2'b01,
        DTR_LUI  = 2'b10,
        DTR_PC4  = 2'b11
    } dtr_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [4:0]        dst;
        logic [31:0]       op_a;
        logic [31:0]       op_b;
    } idex_t;

    // Only the control fields still consumed downstream travel past EXE.
    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic        reg_write;
        logic [1:0]  dtr;
        logic        mem_write;
        logic [4:0]  dst;
        logic [31:0] pc4;
        logic [31:0] lui;
    } exmem_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] lui;
        logic        reg_write;
        logic [1:0]  dtr;
        logic [4:0]  dst;
    } memwb_t;

    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] exe, input logic [31:0] memrd,
                                            input logic [31:0] memalu);
        logic [31:0] r;
        case (sel)
            FWD_RF:    r = rf;
            FWD_EXE:   r = exe;
            FWD_MEMRD: r = memrd;
            default:   r = memalu;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lui_val(input logic [15:0] imm);
        return {imm, 16'h0000};
    endfunction

endpackage

// File: rtl/exe_pipe_regs_if.sv
// Bundle between the control unit / datapath and the EXE-side pipeline registers.
// Plain wires; timing and stalling are owned by the connected modules.
interface exe_pipe_regs_if;
    import exe_pipe_regs_pkg::*;

    logic              stall;
    logic              flush;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_inst;
    logic [31:0]       id_pc;
    logic [4:0]        id_dst;
    logic [31:0]       id_rs_data;
    logic [31:0]       id_rt_data;
    logic [1:0]        exe_f_a;
    logic [1:0]        exe_f_b;
    logic [31:0]       exe_alu_out;
    logic [31:0]       mem_rdata;

    logic [CTRL_W-1:0] exe_ctrl;
    logic [31:0]       exe_inst;
    logic [31:0]       exe_pc;
    logic [31:0]       exe_op_a;
    logic [31:0]       exe_op_b;
    logic [31:0]       mem_alu_out;
    logic [31:0]       mem_store_data;
    logic              mem_MemWrite;
    logic [4:0]        reg_addr_mem;
    logic [4:0]        reg_addr_wb;
    logic              mem_RegWrite;
    logic              wb_RegWrite;
    logic [1:0]        mem_DatatoReg;
    logic [1:0]        wb_DatatoReg;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              if_id_hold;

    modport master (
        output stall, flush, id_ctrl, id_inst, id_pc, id_dst, id_rs_data, id_rt_data,
               exe_f_a, exe_f_b, exe_alu_out, mem_rdata,
        input  exe_ctrl, exe_inst, exe_pc, exe_op_a, exe_op_b, mem_alu_out, mem_store_data,
               mem_MemWrite, reg_addr_mem, reg_addr_wb, mem_RegWrite, wb_RegWrite,
               mem_DatatoReg, wb_DatatoReg, rf_we, rf_waddr, rf_wdata, if_id_hold
    );

    modport slave (
        input  stall, flush, id_ctrl, id_inst, id_pc, id_dst, id_rs_data, id_rt_data,
               exe_f_a, exe_f_b, exe_alu_out, mem_rdata,
        output exe_ctrl, exe_inst, exe_pc, exe_op_a, exe_op_b, mem_alu_out, mem_store_data,
               mem_MemWrite, reg_addr_mem, reg_addr_wb, mem_RegWrite, wb_RegWrite,
               mem_DatatoReg, wb_DatatoReg, rf_we, rf_waddr, rf_wdata, if_id_hold
    );

endinterface

// File: rtl/exe_pipe_regs_pipe_reg.sv
// Generic stage register: clear-to-bubble wins over load, otherwise holds; 1-cycle latency.
// No backpressure of its own; the owner decides clr/en each cycle.
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/exe_pipe_regs.sv
// ID/EX, EX/MEM, MEM/WB registers with operand forwarding; accept at edge N, RF write at N+3.
// Stall/flush turn the ID/EX load into a bubble; later stages always advance.
module exe_pipe_regs
    import exe_pipe_regs_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    exe_pipe_regs_if.slave  bus
);

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    logic [31:0] rf_wdata_d;

    always_comb begin
        idex_d      = '0;
        idex_d.ctrl = bus.id_ctrl;
        idex_d.inst = bus.id_inst;
        idex_d.pc   = bus.id_pc;
        idex_d.dst  = bus.id_dst;
        idex_d.op_a = fwd_sel(bus.exe_f_a, bus.id_rs_data, bus.exe_alu_out,
                              bus.mem_rdata, exmem_q.alu_out);
        idex_d.op_b = fwd_sel(bus.exe_f_b, bus.id_rt_data, bus.exe_alu_out,
                              bus.mem_rdata, exmem_q.alu_out);
    end

    pipe_reg #(.W($bits(idex_t))) u_idex (
        .clk(clk), .rst_n(rst_n), .clr(bus.stall | bus.flush), .en(1'b1),
        .d(idex_d), .q(idex_q)
    );

    always_comb begin
        exmem_d            = '0;
        exmem_d.alu_out    = bus.exe_alu_out;
        exmem_d.store_data = idex_q.op_b;
        exmem_d.reg_write  = idex_q.ctrl[C_REGWRITE];
        exmem_d.dtr        = idex_q.ctrl[C_DTR_HI:C_DTR_LO];
        exmem_d.mem_write  = idex_q.ctrl[C_MEMWRITE];
        exmem_d.dst        = idex_q.dst;
        exmem_d.pc4        = idex_q.pc + 32'd4;
        exmem_d.lui        = lui_val(idex_q.inst[15:0]);
    end

    pipe_reg #(.W($bits(exmem_t))) u_exmem (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(1'b1),
        .d(exmem_d), .q(exmem_q)
    );

    always_comb begin
        memwb_d           = '0;
        memwb_d.alu_out   = exmem_q.alu_out;
        memwb_d.rdata     = bus.mem_rdata;
        memwb_d.pc4       = exmem_q.pc4;
        memwb_d.lui       = exmem_q.lui;
        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.dtr       = exmem_q.dtr;
        memwb_d.dst       = exmem_q.dst;
    end

    pipe_reg #(.W($bits(memwb_t))) u_memwb (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(1'b1),
        .d(memwb_d), .q(memwb_q)
    );

    always_comb begin
        rf_wdata_d = memwb_q.alu_out;
        case (memwb_q.dtr)
            DTR_ALU:  rf_wdata_d = memwb_q.alu_out;
            DTR_LOAD: rf_wdata_d = memwb_q.rdata;
            DTR_LUI:  rf_wdata_d = memwb_q.lui;
            default:  rf_wdata_d = memwb_q.pc4;
        endcase
    end

    assign bus.exe_ctrl       = idex_q.ctrl;
    assign bus.exe_inst       = idex_q.inst;
    assign bus.exe_pc         = idex_q.pc;
    assign bus.exe_op_a       = idex_q.op_a;
    assign bus.exe_op_b       = idex_q.op_b;
    // Hazard outputs use the control unit's naming: "mem" is ID/EX, "wb" is EX/MEM.
    assign bus.reg_addr_mem   = idex_q.dst;
    assign bus.mem_RegWrite   = idex_q.ctrl[C_REGWRITE];
    assign bus.mem_DatatoReg  = idex_q.ctrl[C_DTR_HI:C_DTR_LO];
    assign bus.mem_alu_out    = exmem_q.alu_out;
    assign bus.mem_store_data = exmem_q.store_data;
    assign bus.mem_MemWrite   = exmem_q.mem_write;
    assign bus.reg_addr_wb    = exmem_q.dst;
    assign bus.wb_RegWrite    = exmem_q.reg_write;
    assign bus.wb_DatatoReg   = exmem_q.dtr;
    assign bus.rf_we          = memwb_q.reg_write & (memwb_q.dst != 5'd0);
    assign bus.rf_waddr       = memwb_q.dst;
    assign bus.rf_wdata       = rf_wdata_d;
    // A flush redirects fetch, so it must not be held back by a simultaneous stall.
    assign bus.if_id_hold     = bus.stall & ~bus.flush;

endmodule

// File: tb/tb_exe_pipe_regs.sv
// Randomized and directed bench for exe_pipe_regs against an instruction-tracking model.
module tb_exe_pipe_regs;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    exe_pipe_regs_if bus();
    exe_pipe_regs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    localparam logic [12:0] CT_ALU = 13'h1020;
    localparam logic [12:0] CT_LW  = 13'h1500;
    localparam logic [12:0] CT_LUI = 13'h1800;
    localparam logic [12:0] CT_JAL = 13'h1C00;

    // One record per instruction; it carries every value it picks up on its way down.
    typedef struct {
        logic [12:0] ctrl;
        logic [31:0] inst, pc, a, b, alu, ld;
        logic [4:0]  dst;
    } rec_t;

    rec_t in_exe, in_mem, in_wb;

    function automatic rec_t bubble();
        rec_t r;
        r.ctrl = '0; r.inst = '0; r.pc = '0; r.a = '0; r.b = '0;
        r.alu = '0; r.ld = '0; r.dst = '0;
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                         input logic [31:0] exe, input logic [31:0] rd,
                                         input logic [31:0] ma);
        if (s == 2'd0) return rf;
        if (s == 2'd1) return exe;
        if (s == 2'd2) return rd;
        return ma;
    endfunction

    function automatic logic [31:0] wb_value(input rec_t r);
        logic [15:0] imm;
        imm = r.inst[15:0];
        if (r.ctrl[11:10] == 2'd0) return r.alu;
        if (r.ctrl[11:10] == 2'd1) return r.ld;
        if (r.ctrl[11:10] == 2'd2) return {imm, 16'h0};
        return r.pc + 32'd4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        rec_t nx, nm, nw;
        if (!rst_n) begin
            in_exe <= bubble();
            in_mem <= bubble();
            in_wb  <= bubble();
        end else begin
            nw = in_mem;
            nw.ld = bus.mem_rdata;
            nm = in_exe;
            nm.alu = bus.exe_alu_out;
            nx = bubble();
            if (!(bus.stall || bus.flush)) begin
                nx.ctrl = bus.id_ctrl;
                nx.inst = bus.id_inst;
                nx.pc   = bus.id_pc;
                nx.dst  = bus.id_dst;
                nx.a = pick(bus.exe_f_a, bus.id_rs_data, bus.exe_alu_out, bus.mem_rdata, in_mem.alu);
                nx.b = pick(bus.exe_f_b, bus.id_rt_data, bus.exe_alu_out, bus.mem_rdata, in_mem.alu);
            end
            in_exe <= nx;
            in_mem <= nm;
            in_wb  <= nw;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("exe_ctrl",       32'(bus.exe_ctrl),       32'(in_exe.ctrl));
            chk("exe_inst",       bus.exe_inst,            in_exe.inst);
            chk("exe_pc",         bus.exe_pc,              in_exe.pc);
            chk("exe_op_a",       bus.exe_op_a,            in_exe.a);
            chk("exe_op_b",       bus.exe_op_b,            in_exe.b);
            chk("reg_addr_mem",   32'(bus.reg_addr_mem),   32'(in_exe.dst));
            chk("mem_RegWrite",   32'(bus.mem_RegWrite),   32'(in_exe.ctrl[12]));
            chk("mem_DatatoReg",  32'(bus.mem_DatatoReg),  32'(in_exe.ctrl[11:10]));
            chk("mem_alu_out",    bus.mem_alu_out,         in_mem.alu);
            chk("mem_store_data", bus.mem_store_data,      in_mem.b);
            chk("mem_MemWrite",   32'(bus.mem_MemWrite),   32'(in_mem.ctrl[9]));
            chk("reg_addr_wb",    32'(bus.reg_addr_wb),    32'(in_mem.dst));
            chk("wb_RegWrite",    32'(bus.wb_RegWrite),    32'(in_mem.ctrl[12]));
            chk("wb_DatatoReg",   32'(bus.wb_DatatoReg),   32'(in_mem.ctrl[11:10]));
            chk("rf_we",          32'(bus.rf_we),          32'(in_wb.ctrl[12] && in_wb.dst != 5'd0));
            chk("rf_waddr",       32'(bus.rf_waddr),       32'(in_wb.dst));
            chk("rf_wdata",       bus.rf_wdata,            wb_value(in_wb));
            chk("if_id_hold",     32'(bus.if_id_hold),     32'(bus.stall & ~bus.flush));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [12:0] c, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [4:0] d, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [1:0] fa, input logic [1:0] fb);
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.id_ctrl = c; bus.id_inst = inst; bus.id_pc = pc; bus.id_dst = d;
        bus.id_rs_data = rs; bus.id_rt_data = rt; bus.exe_f_a = fa; bus.exe_f_b = fb;
    endtask

    initial begin
        issue(13'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        bus.exe_alu_out = 32'h0;
        bus.mem_rdata   = 32'h0;
        #2;
        rst_n = 1'b0;
        cmp_en = 1'b1;
        issue(13'h1FFF, 32'hFFFF_FFFF, 32'h1234, 5'd9, 32'h11, 32'h22, 2'd1, 2'd2);
        bus.exe_alu_out = 32'h55;
        bus.mem_rdata   = 32'h66;
        tick(); tick();
        chk("rst_exe_ctrl", 32'(bus.exe_ctrl), 32'h0);
        chk("rst_exe_op_a", bus.exe_op_a, 32'h0);
        chk("rst_mem_alu_out", bus.mem_alu_out, 32'h0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'h0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'h0);
        rst_n = 1'b1;
        issue(CT_ALU, 32'hA5A5_0001, 32'h3C, 5'd2, 32'h1, 32'h2, 2'd0, 2'd0);
        tick();
        chk("first_load_inst", bus.exe_inst, 32'hA5A5_0001);

        // add $3,$1,$2 then dependent sub $4,$3,$1
        issue(CT_ALU, 32'h0022_1820, 32'h40, 5'd3, 32'd5, 32'd7, 2'd0, 2'd0);
        tick();
        bus.exe_alu_out = 32'd12;
        issue(CT_ALU, 32'h0061_2022, 32'h44, 5'd4, 32'd99, 32'd5, 2'd1, 2'd0);
        tick();
        chk("chain_op_a", bus.exe_op_a, 32'd12);
        chk("chain_op_b", bus.exe_op_b, 32'd5);
        chk("chain_mem_alu", bus.mem_alu_out, 32'd12);

        // lw $5 then add $6,$5,$5 with one stall
        bus.exe_alu_out = 32'd7;
        issue(CT_LW, 32'h8C05_0000, 32'h48, 5'd5, 32'h1000, 32'h0, 2'd0, 2'd0);
        tick();
        bus.exe_alu_out = 32'h1000;
        issue(CT_ALU, 32'h00A5_3020, 32'h4C, 5'd6, 32'h0, 32'h0, 2'd0, 2'd0);
        bus.stall = 1'b1;
        #1;
        chk("lu_hold", 32'(bus.if_id_hold), 32'h1);
        tick();
        chk("lu_bubble_ctrl", 32'(bus.exe_ctrl), 32'h0);
        chk("lu_bubble_dst", 32'(bus.reg_addr_mem), 32'h0);
        chk("lu_wb_dst", 32'(bus.reg_addr_wb), 32'd5);
        chk("lu_wb_dtr", 32'(bus.wb_DatatoReg), 32'd1);
        bus.stall = 1'b0;
        bus.exe_f_a = 2'd2; bus.exe_f_b = 2'd2;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.exe_alu_out = 32'h0;
        tick();
        chk("lu_op_a", bus.exe_op_a, 32'hDEAD_BEEF);
        chk("lu_op_b", bus.exe_op_b, 32'hDEAD_BEEF);
        chk("lu_rf_we", 32'(bus.rf_we), 32'h1);
        chk("lu_rf_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("lu_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);

        // two-ahead ALU forward
        bus.exe_alu_out = 32'h40;
        issue(CT_ALU, 32'h0, 32'h50, 5'd7, 32'h1, 32'h2, 2'd0, 2'd0);
        tick();
        bus.exe_alu_out = 32'h3;
        issue(CT_ALU, 32'h0, 32'h54, 5'd8, 32'h1, 32'h99, 2'd0, 2'd3);
        tick();
        chk("fwd11_op_b", bus.exe_op_b, 32'h40);

        // write-back mux: jal, lui, write to $0
        issue(CT_JAL, 32'h0C00_0040, 32'h100, 5'd31, 32'h0, 32'h0, 2'd0, 2'd0);
        tick();
        issue(CT_LUI, 32'h3C08_1234, 32'h104, 5'd8, 32'h0, 32'h0, 2'd0, 2'd0);
        tick();
        issue(CT_ALU, 32'h0, 32'h108, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        tick();
        chk("jal_wdata", bus.rf_wdata, 32'h104);
        chk("jal_waddr", 32'(bus.rf_waddr), 32'd31);
        chk("jal_we", 32'(bus.rf_we), 32'h1);
        issue(13'h0, 32'h0, 32'h10C, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        tick();
        chk("lui_wdata", bus.rf_wdata, 32'h1234_0000);
        chk("lui_we", 32'(bus.rf_we), 32'h1);
        tick();
        chk("r0_we", 32'(bus.rf_we), 32'h0);

        // simultaneous stall and flush
        issue(CT_ALU, 32'h0000_CAFE, 32'h200, 5'd9, 32'h1, 32'h2, 2'd0, 2'd0);
        bus.stall = 1'b1; bus.flush = 1'b1;
        #1;
        chk("sf_hold", 32'(bus.if_id_hold), 32'h0);
        tick();
        chk("sf_ctrl", 32'(bus.exe_ctrl), 32'h0);
        chk("sf_inst", bus.exe_inst, 32'h0);

        // reset in the middle of a stalled sequence
        issue(CT_ALU, 32'h1, 32'h300, 5'd10, 32'h1, 32'h2, 2'd0, 2'd0);
        tick();
        issue(CT_ALU, 32'h2, 32'h304, 5'd11, 32'h1, 32'h2, 2'd0, 2'd0);
        tick();
        bus.stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mr_rf_we", 32'(bus.rf_we), 32'h0);
        chk("mr_wb_dst", 32'(bus.reg_addr_wb), 32'h0);
        issue(13'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_after_we", 32'(bus.rf_we), 32'h0);
        end

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.id_ctrl = 13'($urandom);
            bus.id_inst = $urandom;
            bus.id_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.id_dst = 5'($urandom);
            bus.id_rs_data = $urandom;
            bus.id_rt_data = $urandom;
            bus.exe_f_a = 2'($urandom);
            bus.exe_f_b = 2'($urandom);
            bus.exe_alu_out = $urandom;
            bus.mem_rdata = $urandom;
            tick();
        end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
